dut_result_checker: RTL

- Sits directly downstream of the DUT interface stage. Consumes the captured result stream, which is the RES_FIFO write data and write request.
- Compares each result word against a masked expected word popped from a show-ahead expected-value FIFO.
- Tags each result pass/fail with a vector index, writes tagged records to the result FIFO, and keeps the vector, error, and first-failure counters for the host.
- Runs on the gated DUT clock, so it freezes together with the DUT interface when that stage stalls.

---
 rtl/dut_result_checker.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dut_result_checker.sv
// Result checker behind the DUT interface stage: compares captured result words against
// masked expected words, tags each with pass/fail and a vector index, and keeps host counters.
module dut_result_checker #(
    parameter int RTF_WIDTH = 24,
    parameter int CNT_WIDTH = 16,
    parameter int OUT_WIDTH = RTF_WIDTH + CNT_WIDTH + 1
) (
    input  logic                   clock_gated,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   cfg_stop_on_fail,
    input  logic                   res_valid,
    input  logic [RTF_WIDTH-1:0]   res_data,
    input  logic [2*RTF_WIDTH-1:0] exp_data,
    input  logic                   exp_rdempty,
    output logic                   exp_rdreq,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_wrreq,
    input  logic                   out_wrfull,
    output logic [CNT_WIDTH-1:0]   vector_count,
    output logic [CNT_WIDTH-1:0]   error_count,
    output logic [CNT_WIDTH-1:0]   first_fail_index,
    output logic                   first_fail_valid,
    output logic                   exp_underflow,
    output logic                   out_overflow,
    output logic [1:0]             state_o
);

    // state  | meaning
    // IDLE   | results ignored, no pops, counters hold
    // RUN    | results popped against expected FIFO and compared
    // HALTED | stopped after a failure; results discarded, counters hold
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_t;

    state_t                 state_q, state_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [RTF_WIDTH-1:0]   s1_res_q, s1_exp_q, s1_mask_q;
    logic                   s1_unf_q;
    logic [CNT_WIDTH-1:0]   vc_q, vc_d, ec_q, ec_d, ffi_q, ffi_d;
    logic                   ffv_q, ffv_d, unf_q, unf_d, ovf_q, ovf_d;
    logic [OUT_WIDTH-1:0]   rec_q, rec_d;
    logic                   pend_q, pend_d;
    logic                   cmp_fail;

    assign exp_rdreq = (state_q == ST_RUN) & res_valid & ~exp_rdempty;
    assign cmp_fail  = s1_unf_q | (|((s1_res_q ^ s1_exp_q) & s1_mask_q));

    always_comb begin
        state_d    = state_q;
        s1_valid_d = res_valid & (state_q == ST_RUN);
        vc_d       = vc_q;
        ec_d       = ec_q;
        ffi_d      = ffi_q;
        ffv_d      = ffv_q;
        unf_d      = unf_q;
        ovf_d      = ovf_q;
        rec_d      = rec_q;
        pend_d     = pend_q;

        if (pend_q && !out_wrfull) begin
            pend_d = 1'b0;
        end

        if (s1_valid_q) begin
            if (!(&vc_q)) begin
                vc_d = vc_q + CNT_WIDTH'(1);
            end
            if (cmp_fail) begin
                if (!(&ec_q)) begin
                    ec_d = ec_q + CNT_WIDTH'(1);
                end
                if (!ffv_q) begin
                    ffi_d = vc_q;
                    ffv_d = 1'b1;
                end
                if (cfg_stop_on_fail && state_q == ST_RUN) begin
                    state_d = ST_HALTED;
                end
            end
            if (s1_unf_q) begin
                unf_d = 1'b1;
            end
            // Single holding slot: a record arriving while the slot is still blocked is lost.
            if (pend_q && out_wrfull) begin
                ovf_d = 1'b1;
            end else begin
                rec_d  = {cmp_fail, vc_q, s1_res_q};
                pend_d = 1'b1;
            end
        end

        if (stop && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
        end

        if (start) begin
            state_d    = ST_RUN;
            s1_valid_d = 1'b0;
            vc_d       = '0;
            ec_d       = '0;
            ffi_d      = '0;
            ffv_d      = 1'b0;
            unf_d      = 1'b0;
            ovf_d      = 1'b0;
            rec_d      = '0;
            pend_d     = 1'b0;
        end
    end

    always_ff @(posedge clock_gated or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            s1_valid_q <= 1'b0;
            s1_res_q   <= '0;
            s1_exp_q   <= '0;
            s1_mask_q  <= '0;
            s1_unf_q   <= 1'b0;
            vc_q       <= '0;
            ec_q       <= '0;
            ffi_q      <= '0;
            ffv_q      <= 1'b0;
            unf_q      <= 1'b0;
            ovf_q      <= 1'b0;
            rec_q      <= '0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_res_q   <= res_data;
            s1_exp_q   <= exp_data[2*RTF_WIDTH-1:RTF_WIDTH];
            s1_mask_q  <= exp_data[RTF_WIDTH-1:0];
            s1_unf_q   <= exp_rdempty;
            vc_q       <= vc_d;
            ec_q       <= ec_d;
            ffi_q      <= ffi_d;
            ffv_q      <= ffv_d;
            unf_q      <= unf_d;
            ovf_q      <= ovf_d;
            rec_q      <= rec_d;
            pend_q     <= pend_d;
        end
    end

    assign out_data         = rec_q;
    assign out_wrreq        = pend_q & ~out_wrfull;
    assign vector_count     = vc_q;
    assign error_count      = ec_q;
    assign first_fail_index = ffi_q;
    assign first_fail_valid = ffv_q;
    assign exp_underflow    = unf_q;
    assign out_overflow     = ovf_q;
    assign state_o          = state_q;

endmodule
